pattern_vg_ext: RTL and testbench



---
 rtl/pattern_vg_pkg.sv | 25 ++
 rtl/pattern_vg_ext_sat_accum.sv | 34 +++
 rtl/pattern_vg_ext.sv | 168 ++++++++++++++++
 tb/tb_pattern_vg_ext.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pattern_vg_pkg.sv
// Shared constants for the pattern overlay stage: pattern codes, the colour-bar
// table and per-channel full-scale/zero levels.
package pattern_vg_pkg;

   typedef enum logic [7:0] {
      PAT_NONE   = 8'd0,
      PAT_BORDER = 8'd1,
      PAT_MOIREX = 8'd2,
      PAT_MOIREY = 8'd3,
      PAT_HRAMP  = 8'd4,
      PAT_VRAMP  = 8'd5,
      PAT_CBAR   = 8'd6,
      PAT_CHECK  = 8'd7,
      PAT_MOVBAR = 8'd8
   } pat_e;

   // {r,g,b} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [0:7][2:0] CBAR_RGB = {
      3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
   };

   localparam logic CH_WHITE = 1'b1;
   localparam logic CH_BLACK = 1'b0;

endpackage

// File: rtl/pattern_vg_ext_sat_accum.sv
// Saturating fixed-point accumulator; exposes the integer part of either the
// stored value or the value about to be stored.
module sat_accum #(
   parameter int W       = 20,
   parameter int F       = 12,
   parameter bit OUT_SUM = 1'b0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           clear,
   input  logic           en,
   input  logic [W-1:0]   step,
   output logic [W-F-1:0] val
);
   logic [W-1:0] q, sum;
   logic [W:0]   add;

   assign add = {1'b0, q} + {1'b0, step};

   always_comb begin
      sum = add[W-1:0];
      if (load) sum = step;
      else if (add[W]) sum = '1;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) q <= '0;
      else if (en) q <= sum;
   end

   assign val = OUT_SUM ? sum[W-1:F] : q[W-1:F];

endmodule

// File: rtl/pattern_vg_ext.sv
// Video pattern overlay: ramps, colour bars, checkerboard and moving bar on the
// x/y/sync bus, one clock of latency, pattern switches latched at frame start.
module pattern_vg_ext
   import pattern_vg_pkg::*;
#(
   parameter int B               = 8,
   parameter int X_BITS          = 13,
   parameter int Y_BITS          = 13,
   parameter int FRACTIONAL_BITS = 12,
   parameter int CELL_LOG2       = 5,
   parameter int FC_BITS         = 16
) (
   input  logic                        clk_in,
   input  logic                        reset,
   input  logic [X_BITS-1:0]           x,
   input  logic [Y_BITS-1:0]           y,
   input  logic                        vn_in,
   input  logic                        hn_in,
   input  logic                        dn_in,
   input  logic [B-1:0]                r_in,
   input  logic [B-1:0]                g_in,
   input  logic [B-1:0]                b_in,
   input  logic [X_BITS-1:0]           total_active_pix,
   input  logic [Y_BITS-1:0]           total_active_lines,
   input  logic [7:0]                  pattern,
   input  logic [B+FRACTIONAL_BITS-1:0] ramp_step,
   input  logic [X_BITS-1:0]           move_step,
   output logic                        vn_out,
   output logic                        hn_out,
   output logic                        den_out,
   output logic [B-1:0]                r_out,
   output logic [B-1:0]                g_out,
   output logic [B-1:0]                b_out,
   output logic [FC_BITS-1:0]          frame_count,
   output logic [7:0]                  pattern_active
);
   localparam int AW = B + FRACTIONAL_BITS;
   localparam int XW = X_BITS + 1;

   logic       fs, x_first, x_last, y_first, y_last;
   logic [7:0] pattern_q, pat_eff;

   assign x_first = (x == '0);
   assign x_last  = (x == total_active_pix - X_BITS'(1));
   assign y_first = (y == '0);
   assign y_last  = (y == total_active_lines - Y_BITS'(1));
   assign fs      = dn_in & x_first & y_first;
   // the frame-start pixel already shows the newly requested pattern
   assign pat_eff = fs ? pattern : pattern_q;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         pattern_q   <= '0;
         frame_count <= '0;
      end else if (fs) begin
         pattern_q   <= pattern;
         frame_count <= frame_count + FC_BITS'(1);
      end
   end
   assign pattern_active = pattern_q;

   logic [B-1:0] h_val, v_val;

   sat_accum #(.W(AW), .F(FRACTIONAL_BITS), .OUT_SUM(1'b1)) u_h_ramp (
      .clk(clk_in), .reset(reset), .load(x_first), .clear(dn_in & x_last),
      .en(dn_in), .step(ramp_step), .val(h_val)
   );

   sat_accum #(.W(AW), .F(FRACTIONAL_BITS), .OUT_SUM(1'b0)) u_v_ramp (
      .clk(clk_in), .reset(reset), .load(1'b0), .clear(fs),
      .en(dn_in & x_last), .step(ramp_step), .val(v_val)
   );

   logic [X_BITS-1:0] bar_w, bar_cnt, cnt_cur;
   logic [2:0]        bar_idx, idx_cur;

   assign bar_w   = total_active_pix >> 3;
   assign cnt_cur = x_first ? '0 : bar_cnt;
   assign idx_cur = x_first ? '0 : bar_idx;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         bar_cnt <= '0;
         bar_idx <= '0;
      end else if (dn_in) begin
         if (cnt_cur == bar_w - X_BITS'(1)) begin
            bar_cnt <= '0;
            bar_idx <= (idx_cur == 3'd7) ? 3'd7 : idx_cur + 3'd1;
         end else begin
            bar_cnt <= cnt_cur + X_BITS'(1);
            bar_idx <= idx_cur;
         end
      end
   end

   logic [X_BITS-1:0] bar_pos, pos_next, pos_cur;
   logic [XW-1:0]     pos_sum;
   logic              in_bar;

   assign pos_sum  = {1'b0, bar_pos} + {1'b0, move_step};
   assign pos_next = (pos_sum >= {1'b0, total_active_pix}) ?
                     X_BITS'(pos_sum - {1'b0, total_active_pix}) : X_BITS'(pos_sum);
   assign pos_cur  = fs ? pos_next : bar_pos;
   // right-edge clipping falls out of x never reaching total_active_pix
   assign in_bar   = ({1'b0, x} >= {1'b0, pos_cur}) &&
                     ({1'b0, x} <  {1'b0, pos_cur} + XW'(1 << CELL_LOG2));

   always_ff @(posedge clk_in) begin
      if (reset) bar_pos <= '0;
      else if (fs) bar_pos <= pos_next;
   end

   logic [B-1:0] r_d, g_d, b_d;
   logic [2:0]   cbar;
   logic [B-1:0] wh;

   assign wh   = {B{CH_WHITE}};
   assign cbar = CBAR_RGB[idx_cur];

   always_comb begin
      r_d = {B{CH_BLACK}};
      g_d = {B{CH_BLACK}};
      b_d = {B{CH_BLACK}};
      case (pat_eff)
         PAT_NONE: begin
            r_d = r_in; g_d = g_in; b_d = b_in;
         end
         PAT_BORDER: begin
            if (dn_in && (x_first || y_first || x_last || y_last)) begin
               r_d = wh; g_d = wh; b_d = wh;
            end else begin
               r_d = r_in; g_d = g_in; b_d = b_in;
            end
         end
         PAT_MOIREX: if (x[0]) begin r_d = wh; g_d = wh; b_d = wh; end
         PAT_MOIREY: if (y[0]) begin r_d = wh; g_d = wh; b_d = wh; end
         PAT_HRAMP: begin r_d = h_val; g_d = h_val; b_d = h_val; end
         PAT_VRAMP: if (!fs) begin r_d = v_val; g_d = v_val; b_d = v_val; end
         PAT_CBAR: begin
            r_d = {B{cbar[2]}}; g_d = {B{cbar[1]}}; b_d = {B{cbar[0]}};
         end
         PAT_CHECK:
            if (x[CELL_LOG2] ^ y[CELL_LOG2]) begin r_d = wh; g_d = wh; b_d = wh; end
         PAT_MOVBAR: begin
            if (in_bar) begin
               r_d = wh; g_d = wh; b_d = wh;
            end else begin
               r_d = r_in; g_d = g_in; b_d = b_in;
            end
         end
         default: ;
      endcase
      if (!dn_in && pat_eff != PAT_NONE && pat_eff != PAT_BORDER) begin
         r_d = {B{CH_BLACK}}; g_d = {B{CH_BLACK}}; b_d = {B{CH_BLACK}};
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         vn_out <= 1'b0; hn_out <= 1'b0; den_out <= 1'b0;
         r_out  <= '0;   g_out  <= '0;   b_out   <= '0;
      end else begin
         vn_out <= vn_in; hn_out <= hn_in; den_out <= dn_in;
         r_out  <= r_d;   g_out  <= g_d;   b_out   <= b_d;
      end
   end

endmodule

// File: tb/tb_pattern_vg_ext.sv
// Scoreboard bench: the driver pushes expected outputs from a raster-level
// model; a monitor pops and compares one entry per clock.
module tb_pattern_vg_ext;
   localparam int B = 8, XB = 13, YB = 13, FR = 12, CL = 2, FCB = 16;
   localparam int AW = B + FR;

   logic          clk_in = 1'b0, reset = 1'b0;
   logic [XB-1:0] x = '0, total_active_pix = '0, move_step = '0;
   logic [YB-1:0] y = '0, total_active_lines = '0;
   logic          vn_in = 1'b0, hn_in = 1'b0, dn_in = 1'b0;
   logic [B-1:0]  r_in = '0, g_in = '0, b_in = '0;
   logic [7:0]    pattern = '0;
   logic [AW-1:0] ramp_step = '0;
   logic          vn_out, hn_out, den_out;
   logic [B-1:0]  r_out, g_out, b_out;
   logic [FCB-1:0] frame_count;
   logic [7:0]    pattern_active;

   pattern_vg_ext #(.B(B), .X_BITS(XB), .Y_BITS(YB), .FRACTIONAL_BITS(FR),
                    .CELL_LOG2(CL), .FC_BITS(FCB)) dut (
      .clk_in(clk_in), .reset(reset), .x(x), .y(y),
      .vn_in(vn_in), .hn_in(hn_in), .dn_in(dn_in),
      .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .total_active_pix(total_active_pix), .total_active_lines(total_active_lines),
      .pattern(pattern), .ramp_step(ramp_step), .move_step(move_step),
      .vn_out(vn_out), .hn_out(hn_out), .den_out(den_out),
      .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .frame_count(frame_count), .pattern_active(pattern_active)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic           vn, hn, de;
      logic [B-1:0]   r, g, b;
      logic [FCB-1:0] fc;
      logic [7:0]     pa;
   } exp_t;

   exp_t exp_q[$];
   int n_chk = 0, n_fail = 0;

   // model state
   int     m_pq = 0, m_fc = 0, m_pos = 0, m_move = 0, W = 16, H = 4;
   longint m_step = 0;

   function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t actual=%0d expected=%0d", n, $time, act, exp);
      end
   endfunction

   function automatic longint sat_ramp(longint mult);
      longint s, mx;
      mx = (longint'(1) << AW) - 1;
      s  = mult * m_step;
      if (s > mx) s = mx;
      return s >> FR;
   endfunction

   task automatic cyc(input bit rst, input bit de, input int xi, input int yi, input int pat);
      exp_t e;
      int kind, idx;
      longint gv;
      bit [2:0] rgb;
      @(negedge clk_in);
      reset = rst; dn_in = de; x = XB'(xi); y = YB'(yi); pattern = 8'(pat);
      vn_in = 1'($urandom); hn_in = 1'($urandom);
      r_in = B'($urandom); g_in = B'($urandom); b_in = B'($urandom);
      total_active_pix = XB'(W); total_active_lines = YB'(H);
      ramp_step = AW'(m_step); move_step = XB'(m_move);
      if (rst) begin
         m_pq = 0; m_fc = 0; m_pos = 0;
         e = '{1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0};
      end else begin
         if (de && xi == 0 && yi == 0) begin
            m_pq  = pat;
            m_fc  = (m_fc + 1) % (1 << FCB);
            m_pos = (m_pos + m_move) % W;
         end
         e.vn = vn_in; e.hn = hn_in; e.de = de;
         e.fc = FCB'(m_fc); e.pa = 8'(m_pq);
         kind = 2; gv = 0; rgb = 3'b000;   // 0 pass, 1 white, 2 black, 3 gray, 4 bar colour
         if (!de) kind = (m_pq <= 1) ? 0 : 2;
         else case (m_pq)
            0: kind = 0;
            1: kind = (xi == 0 || yi == 0 || xi == W-1 || yi == H-1) ? 1 : 0;
            2: kind = (xi % 2 == 1) ? 1 : 2;
            3: kind = (yi % 2 == 1) ? 1 : 2;
            4: begin kind = 3; gv = sat_ramp(longint'(xi + 1)); end
            5: begin kind = 3; gv = sat_ramp(longint'(yi)); end
            6: begin
               kind = 4;
               idx = xi / (W / 8);
               if (idx > 7) idx = 7;
               case (idx)
                  0: rgb = 3'b111;  // white
                  1: rgb = 3'b110;  // yellow
                  2: rgb = 3'b011;  // cyan
                  3: rgb = 3'b010;  // green
                  4: rgb = 3'b101;  // magenta
                  5: rgb = 3'b100;  // red
                  6: rgb = 3'b001;  // blue
                  default: rgb = 3'b000;
               endcase
            end
            7: kind = ((((xi >> CL) ^ (yi >> CL)) & 1) == 1) ? 1 : 2;
            8: kind = (xi >= m_pos && xi < m_pos + (1 << CL)) ? 1 : 0;
            default: kind = 2;
         endcase
         case (kind)
            0: begin e.r = r_in; e.g = g_in; e.b = b_in; end
            1: begin e.r = '1; e.g = '1; e.b = '1; end
            3: begin e.r = B'(gv); e.g = B'(gv); e.b = B'(gv); end
            4: begin e.r = {B{rgb[2]}}; e.g = {B{rgb[1]}}; e.b = {B{rgb[0]}}; end
            default: begin e.r = '0; e.g = '0; e.b = '0; end
         endcase
      end
      exp_q.push_back(e);
   endtask

   // raster frame; pattern input switches from p1 to p2 halfway down
   task automatic frame(input int w, input int h, input int p1, input int p2, input int rst_at);
      int p;
      W = w; H = h;
      for (int yy = 0; yy < h; yy++) begin
         p = (yy < h / 2) ? p1 : p2;
         for (int xx = 0; xx < w; xx++)
            cyc(yy * w + xx == rst_at, 1'b1, xx, yy, p);
         for (int k = 0; k < 2; k++)
            cyc(1'b0, 1'b0, $urandom_range(0, w + 3), yy, p);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk_in);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("vn_out",  32'(vn_out),  32'(e.vn));
            chk("hn_out",  32'(hn_out),  32'(e.hn));
            chk("den_out", 32'(den_out), 32'(e.de));
            chk("r_out",   32'(r_out),   32'(e.r));
            chk("g_out",   32'(g_out),   32'(e.g));
            chk("b_out",   32'(b_out),   32'(e.b));
            chk("frame_count",    32'(frame_count),    32'(e.fc));
            chk("pattern_active", 32'(pattern_active), 32'(e.pa));
         end
      end
   end

   initial begin
      int hh, p1, p2;
      cyc(1'b1, 1'b0, 0, 0, 0);
      cyc(1'b1, 1'b0, 0, 0, 0);
      // horizontal ramp saturation, then switch 4 -> 6 mid-frame
      m_step = 64'h20000; m_move = 0;
      frame(16, 4, 4, 6, -1);
      frame(16, 4, 6, 6, -1);
      // colour bars with remainder pixels
      frame(20, 2, 6, 6, -1);
      frame(20, 2, 6, 6, -1);
      // vertical ramp, moire, border
      m_step = 64'h50000;
      frame(16, 4, 5, 5, -1);
      frame(16, 4, 2, 3, -1);
      frame(16, 4, 3, 1, -1);
      frame(16, 4, 1, 1, -1);
      // checkerboard
      frame(8, 8, 7, 7, -1);
      // mid-frame reset with checker active
      frame(16, 4, 7, 7, -1);
      frame(16, 4, 7, 7, 21);
      frame(16, 4, 7, 7, -1);
      // moving bar wrap from a clean bar_pos
      cyc(1'b1, 1'b0, 0, 0, 0);
      m_move = 12;
      frame(32, 2, 8, 8, -1);
      frame(32, 2, 8, 8, -1);
      frame(32, 2, 8, 8, -1);
      frame(32, 2, 8, 8, -1);
      // randomized frames at a fixed width
      cyc(1'b1, 1'b0, 0, 0, 0);
      for (int f = 0; f < 10; f++) begin
         hh = $urandom_range(2, 5);
         p1 = $urandom_range(0, 10);
         p2 = $urandom_range(0, 10);
         m_step = longint'($urandom_range(0, (1 << AW) - 1));
         if (f % 3 == 0) m_step = longint'($urandom_range(0, 32'h8000));
         m_move = $urandom_range(0, 31);
         frame(32, hh, p1, p2, -1);
      end
      for (int k = 0; k < 4; k++) @(negedge clk_in);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
